// File: rtl/hazard_control_unit_if.sv
// Hazard-control bundle between the pipeline datapath and the hazard controller.
// The master side is the pipeline (sources hazard inputs, consumes stall/flush enables).
interface hazard_control_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_is_load;
  logic             ex_br_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_mem_stall;
  logic             mem_wb_flush;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load, ex_br_taken,
    output dmem_req, dmem_ready,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    input  ex_mem_stall, mem_wb_flush, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load, ex_br_taken,
    input  dmem_req, dmem_ready,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    output ex_mem_stall, mem_wb_flush, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage pipeline: load-use bubbles, branch flushes,
// data-memory freeze with timeout, and saturating stall/flush performance counters.
module hazard_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input logic clk,
  input logic rst_n,
  hazard_control_unit_if.slave hz_io
);

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StMemWait = 2'd1;
  localparam logic [1:0] StHung    = 2'd2;

  localparam logic [15:0] TimeoutVal = 16'(MEM_TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_busy;
  logic load_use;
  logic freeze;

  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic ex_mem_stall, mem_wb_flush;

  // Hazard detection from the current ID/EX/MEM contents.
  always_comb begin
    mem_busy = hz_io.dmem_req && !hz_io.dmem_ready;
    load_use = hz_io.ex_is_load && (hz_io.ex_rd != 5'd0) &&
               ((hz_io.id_use_rs1 && (hz_io.id_rs1 == hz_io.ex_rd)) ||
                (hz_io.id_use_rs2 && (hz_io.id_rs2 == hz_io.ex_rd)));
    freeze   = (state_q == StHung) || mem_busy;
  end

  // Prioritised control outputs: freeze beats branch flush beats load-use bubble.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    if (freeze) begin
      // EX is held, so branch and load-use simply re-evaluate once released.
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (hz_io.ex_br_taken) begin
      // ID holds a wrong-path instruction, so any load-use match is irrelevant.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  // Memory-wait FSM and its wait-cycle counter.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      StRun: begin
        if (mem_busy) begin
          state_d = StMemWait;
          wait_d  = 16'd1;
        end
      end
      StMemWait: begin
        if (!mem_busy) begin
          state_d = StRun;
          wait_d  = 16'd0;
        end else if (wait_q == TimeoutVal) begin
          state_d = StHung;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      StHung: begin
        state_d = StHung;
      end
      default: begin
        state_d = StRun;
        wait_d  = 16'd0;
      end
    endcase
  end

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (if_id_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      wait_q      <= 16'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Drive the interface outputs.
  always_comb begin
    hz_io.pc_stall     = pc_stall;
    hz_io.if_id_stall  = if_id_stall;
    hz_io.if_id_flush  = if_id_flush;
    hz_io.id_ex_stall  = id_ex_stall;
    hz_io.id_ex_flush  = id_ex_flush;
    hz_io.ex_mem_stall = ex_mem_stall;
    hz_io.mem_wb_flush = mem_wb_flush;
    hz_io.mem_timeout  = (state_q == StHung);
    hz_io.stall_cnt    = stall_cnt_q;
    hz_io.flush_cnt    = flush_cnt_q;
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit (MEM_TIMEOUT=4, CNT_W=4): each step drives
// inputs, pushes its expected outputs to a scoreboard, and compares at the falling edge.
module tb_hazard_control_unit;

  localparam int unsigned Cw = 4;

  // Control vector: pc_stall, if_id_stall, if_id_flush, id_ex_stall,
  // id_ex_flush, ex_mem_stall, mem_wb_flush, mem_timeout
  localparam logic [7:0] None = 8'b0000_0000;
  localparam logic [7:0] Frz  = 8'b1101_0110;
  localparam logic [7:0] Hung = 8'b1101_0111;
  localparam logic [7:0] Lu   = 8'b1100_1000;
  localparam logic [7:0] Br   = 8'b0010_1000;

  typedef struct packed {
    logic [7:0]    ctrl;
    logic [Cw-1:0] sc;
    logic [Cw-1:0] fc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  hazard_control_unit_if #(.CNT_W(Cw)) bus ();

  hazard_control_unit #(
    .MEM_TIMEOUT(4),
    .CNT_W      (Cw)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_idle();
    bus.id_rs1      = 5'd0;
    bus.id_rs2      = 5'd0;
    bus.id_use_rs1  = 1'b0;
    bus.id_use_rs2  = 1'b0;
    bus.ex_rd       = 5'd0;
    bus.ex_is_load  = 1'b0;
    bus.ex_br_taken = 1'b0;
    bus.dmem_req    = 1'b0;
    bus.dmem_ready  = 1'b0;
  endtask

  // Load x5 in EX, ID reads x5 through rs1.
  task automatic set_lu();
    bus.ex_is_load = 1'b1;
    bus.ex_rd      = 5'd5;
    bus.id_rs1     = 5'd5;
    bus.id_use_rs1 = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [7:0] ec, input int sc, input int fc);
    exp_t e;
    logic [7:0] obs;
    exp_q.push_back({ec, Cw'(sc), Cw'(fc)});
    @(negedge clk);
    e   = exp_q.pop_front();
    obs = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_stall,
           bus.id_ex_flush, bus.ex_mem_stall, bus.mem_wb_flush, bus.mem_timeout};
    checks++;
    assert (obs === e.ctrl) else begin
      errors++;
      $error("FAIL %s ctrl observed=%b expected=%b", tag, obs, e.ctrl);
    end
    checks++;
    assert (bus.stall_cnt === e.sc) else begin
      errors++;
      $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, bus.stall_cnt, e.sc);
    end
    checks++;
    assert (bus.flush_cnt === e.fc) else begin
      errors++;
      $error("FAIL %s flush_cnt observed=%0d expected=%0d", tag, bus.flush_cnt, e.fc);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    set_idle();

    // Reset: counters held at 0, outputs follow RUN equations.
    chk("rst_idle", None, 0, 0);
    set_lu();
    chk("rst_lu", Lu, 0, 0);
    set_idle();
    rst_n = 1'b1;
    chk("idle", None, 0, 0);

    // Single load-use bubble.
    set_lu();
    chk("lu", Lu, 0, 0);
    set_idle();
    chk("lu_after", None, 1, 0);

    // ex_rd = 0 never stalls.
    bus.ex_is_load = 1'b1;
    bus.ex_rd      = 5'd0;
    bus.id_rs1     = 5'd0;
    bus.id_use_rs1 = 1'b1;
    chk("rd_zero", None, 1, 0);

    // Matching register not actually read.
    set_lu();
    bus.id_use_rs1 = 1'b0;
    bus.id_use_rs2 = 1'b1;
    bus.id_rs2     = 5'd3;
    chk("no_use", None, 1, 0);

    // Match through rs2.
    bus.id_rs2 = 5'd5;
    chk("lu_rs2", Lu, 1, 0);

    // Branch beats load-use.
    bus.ex_br_taken = 1'b1;
    chk("br_lu", Br, 2, 0);
    set_idle();
    chk("post_br", None, 2, 1);

    // Three wait cycles with a branch held in EX.
    bus.dmem_req    = 1'b1;
    bus.ex_br_taken = 1'b1;
    chk("mw_1", Frz, 2, 1);
    chk("mw_2", Frz, 3, 1);
    chk("mw_3", Frz, 4, 1);
    bus.dmem_ready = 1'b1;
    chk("mw_release", Br, 5, 1);
    set_idle();
    chk("mw_done", None, 5, 2);

    // Zero-wait access.
    bus.dmem_req   = 1'b1;
    bus.dmem_ready = 1'b1;
    chk("zero_wait", None, 5, 2);

    // Request withdrawn mid-wait releases the freeze.
    bus.dmem_ready = 1'b0;
    chk("wd_1", Frz, 5, 2);
    bus.dmem_req = 1'b0;
    chk("wd_drop", None, 6, 2);

    // Timeout: 5 frozen cycles then HUNG, absorbing.
    bus.dmem_req = 1'b1;
    for (int i = 0; i < 5; i++) chk("to_frz", Frz, 6 + i, 2);
    chk("hung", Hung, 11, 2);
    bus.dmem_req   = 1'b0;
    bus.dmem_ready = 1'b1;
    chk("hung_hold", Hung, 12, 2);

    // Asynchronous reset out of HUNG.
    set_idle();
    rst_n = 1'b0;
    chk("rst_hung", None, 0, 0);
    rst_n = 1'b1;
    chk("after_rst", None, 0, 0);

    // 20 consecutive load-use cycles saturate the 4-bit counter.
    set_lu();
    for (int i = 0; i < 20; i++) chk("sat", Lu, (i < 15) ? i : 15, 0);
    set_idle();
    chk("sat_end", None, 15, 0);

    // Reset mid-wait, then a full timeout from a clean wait counter.
    bus.dmem_req = 1'b1;
    chk("rmw_1", Frz, 15, 0);
    chk("rmw_2", Frz, 15, 0);
    set_idle();
    rst_n = 1'b0;
    chk("rst_mw", None, 0, 0);
    rst_n = 1'b1;
    bus.dmem_req = 1'b1;
    for (int i = 0; i < 5; i++) chk("to2_frz", Frz, i, 0);
    chk("hung2", Hung, 5, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
